// File: rtl/zynq_m00_axi_rr_sched.sv
// rtl/zynq_m00_axi_rr_sched.sv - round-robin sharing of one AXI3 master port between requesters
//
// Purpose: arbitrates burst commands from num_req_p requesters and runs one
// AXI3 transaction at a time on m00_axi (AW->W->B or AR->R). It steers write
// beats from the owning requester to the port and read beats back to the
// owner, then pulses per-requester completion with an error flag.
//
// Ports:
//   m00_axi_aclk/aresetn       clock, synchronous active-low reset
//   req_v/w/addr/len_i         per-requester command (valid, dir, address, beats-1)
//   req_yumi_o                 one-hot command accept pulse
//   wdata/wstrb/wdata_v_i      per-requester write beat, wdata_yumi_o one-hot consume
//   rdata_o/rdata_v_o          shared read data, one-hot read valid, rdata_ready_i per requester
//   done_v_o/done_err_o        one-hot completion pulse, error qualifier
//   m00_axi_aw/w/b/ar/r*       AXI3 master channels
module zynq_m00_axi_rr_sched #(
  parameter int num_req_p    = 2,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64
) (
  input  logic                                  m00_axi_aclk,
  input  logic                                  m00_axi_aresetn,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p-1:0]                  req_w_i,
  input  logic [num_req_p*addr_width_p-1:0]     req_addr_i,
  input  logic [num_req_p*4-1:0]                req_len_i,
  output logic [num_req_p-1:0]                  req_yumi_o,
  input  logic [num_req_p*data_width_p-1:0]     wdata_i,
  input  logic [num_req_p*data_width_p/8-1:0]   wstrb_i,
  input  logic [num_req_p-1:0]                  wdata_v_i,
  output logic [num_req_p-1:0]                  wdata_yumi_o,
  output logic [data_width_p-1:0]               rdata_o,
  output logic [num_req_p-1:0]                  rdata_v_o,
  input  logic [num_req_p-1:0]                  rdata_ready_i,
  output logic [num_req_p-1:0]                  done_v_o,
  output logic                                  done_err_o,
  output logic [addr_width_p-1:0]               m00_axi_awaddr,
  output logic                                  m00_axi_awvalid,
  output logic [5:0]                            m00_axi_awid,
  output logic [3:0]                            m00_axi_awlen,
  output logic [2:0]                            m00_axi_awsize,
  output logic [1:0]                            m00_axi_awburst,
  output logic [1:0]                            m00_axi_awlock,
  output logic [3:0]                            m00_axi_awcache,
  output logic [2:0]                            m00_axi_awprot,
  output logic [3:0]                            m00_axi_awqos,
  input  logic                                  m00_axi_awready,
  output logic [data_width_p-1:0]               m00_axi_wdata,
  output logic [data_width_p/8-1:0]             m00_axi_wstrb,
  output logic                                  m00_axi_wvalid,
  output logic                                  m00_axi_wlast,
  output logic [5:0]                            m00_axi_wid,
  input  logic                                  m00_axi_wready,
  output logic                                  m00_axi_bready,
  input  logic                                  m00_axi_bvalid,
  input  logic [5:0]                            m00_axi_bid,
  input  logic [1:0]                            m00_axi_bresp,
  output logic [addr_width_p-1:0]               m00_axi_araddr,
  output logic                                  m00_axi_arvalid,
  output logic [5:0]                            m00_axi_arid,
  output logic [3:0]                            m00_axi_arlen,
  output logic [2:0]                            m00_axi_arsize,
  output logic [1:0]                            m00_axi_arburst,
  output logic [1:0]                            m00_axi_arlock,
  output logic [3:0]                            m00_axi_arcache,
  output logic [2:0]                            m00_axi_arprot,
  output logic [3:0]                            m00_axi_arqos,
  input  logic                                  m00_axi_arready,
  output logic                                  m00_axi_rready,
  input  logic [data_width_p-1:0]               m00_axi_rdata,
  input  logic                                  m00_axi_rvalid,
  input  logic [5:0]                            m00_axi_rid,
  input  logic                                  m00_axi_rlast,
  input  logic [1:0]                            m00_axi_rresp
);

  localparam int idx_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int strb_w = data_width_p / 8;
  localparam logic [2:0] size_c = 3'($clog2(data_width_p / 8));
  localparam logic [num_req_p-1:0] one_c = num_req_p'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R} state_e;

  state_e                  state_q;
  logic [idx_w-1:0]        rr_q, owner_q;
  logic [addr_width_p-1:0] addr_q;
  logic [3:0]              len_q, cnt_q;
  logic                    err_q;

  logic [idx_w-1:0]        grant_idx;
  logic                    grant_v;
  logic [addr_width_p-1:0] grant_addr;
  logic [3:0]              grant_len;
  logic                    grant_w;
  logic [2*num_req_p-1:0]  req_shift;
  logic [num_req_p-1:0]    owner_oh;
  logic                    owner_wv, r_fire, b_fire, r_beat_err;
  logic                    unused_ids;

  // IDs are always 0 with a single outstanding transaction, so responses are not matched.
  assign unused_ids = ^{m00_axi_bid, m00_axi_rid};

  function automatic logic [idx_w-1:0] add_wrap(input logic [idx_w-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= num_req_p) s = s - num_req_p;
    return idx_w'(s);
  endfunction

  // Rotate requests so bit k means requester (rr_q + k); the lowest set bit wins.
  assign req_shift = {req_v_i, req_v_i} >> rr_q;

  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (req_shift[k]) begin
        grant_v   = 1'b1;
        grant_idx = add_wrap(rr_q, k);
      end
    end
    grant_v = grant_v & m00_axi_aresetn & (state_q == ST_IDLE);
  end

  always_comb begin
    grant_addr    = '0;
    grant_len     = '0;
    grant_w       = 1'b0;
    m00_axi_wdata = '0;
    m00_axi_wstrb = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant_idx == idx_w'(i)) begin
        grant_addr = req_addr_i[i*addr_width_p +: addr_width_p];
        grant_len  = req_len_i[i*4 +: 4];
        grant_w    = req_w_i[i];
      end
      if (owner_q == idx_w'(i)) begin
        m00_axi_wdata = wdata_i[i*data_width_p +: data_width_p];
        m00_axi_wstrb = wstrb_i[i*strb_w +: strb_w];
      end
    end
  end

  assign owner_oh = one_c << owner_q;
  assign owner_wv = |(wdata_v_i & owner_oh);

  assign req_yumi_o = grant_v ? (one_c << grant_idx) : '0;

  assign m00_axi_awvalid = (state_q == ST_AW);
  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_awlen   = len_q;
  assign m00_axi_awid    = '0;
  assign m00_axi_awsize  = size_c;
  assign m00_axi_awburst = 2'b01;
  assign m00_axi_awlock  = 2'b00;
  assign m00_axi_awcache = 4'b0011;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awqos   = 4'b0000;

  assign m00_axi_arvalid = (state_q == ST_AR);
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_arlen   = len_q;
  assign m00_axi_arid    = '0;
  assign m00_axi_arsize  = size_c;
  assign m00_axi_arburst = 2'b01;
  assign m00_axi_arlock  = 2'b00;
  assign m00_axi_arcache = 4'b0011;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arqos   = 4'b0000;

  assign m00_axi_wvalid = (state_q == ST_W) & owner_wv;
  assign m00_axi_wlast  = (state_q == ST_W) & (cnt_q == 4'd0);
  assign m00_axi_wid    = '0;
  assign wdata_yumi_o   = (m00_axi_wvalid & m00_axi_wready) ? owner_oh : '0;

  assign m00_axi_bready = (state_q == ST_B);
  assign b_fire         = (state_q == ST_B) & m00_axi_bvalid;

  assign m00_axi_rready = (state_q == ST_R) & |(rdata_ready_i & owner_oh);
  assign rdata_o        = m00_axi_rdata;
  assign rdata_v_o      = ((state_q == ST_R) & m00_axi_rvalid) ? owner_oh : '0;
  assign r_fire         = (state_q == ST_R) & m00_axi_rvalid & m00_axi_rready;

  // Error sources on a read beat: bad response, a beat past the expected
  // last one, or rlast arriving before the expected beat count.
  assign r_beat_err = (m00_axi_rresp != 2'b00)
                    | ((cnt_q == 4'd0) & ~m00_axi_rlast)
                    | (m00_axi_rlast & (cnt_q != 4'd0));

  assign done_v_o   = (b_fire | (r_fire & m00_axi_rlast)) ? owner_oh : '0;
  assign done_err_o = (b_fire & (err_q | (m00_axi_bresp != 2'b00)))
                    | (r_fire & m00_axi_rlast & (err_q | r_beat_err));

  always_ff @(posedge m00_axi_aclk) begin
    if (!m00_axi_aresetn) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (grant_v) begin
          owner_q <= grant_idx;
          addr_q  <= grant_addr;
          len_q   <= grant_len;
          cnt_q   <= grant_len;
          err_q   <= 1'b0;
          rr_q    <= add_wrap(grant_idx, 1);
          state_q <= grant_w ? ST_AW : ST_AR;
        end
        ST_AW: if (m00_axi_awready) state_q <= ST_W;
        ST_W: if (m00_axi_wvalid && m00_axi_wready) begin
          if (cnt_q == 4'd0) state_q <= ST_B;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_B: if (m00_axi_bvalid) state_q <= ST_IDLE;
        ST_AR: if (m00_axi_arready) state_q <= ST_R;
        ST_R: if (r_fire) begin
          err_q <= err_q | r_beat_err;
          // Saturate so an overrunning burst keeps reporting until rlast.
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          if (m00_axi_rlast) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zynq_m00_axi_rr_sched.sv
// tb/tb_zynq_m00_axi_rr_sched.sv - self-checking bench for zynq_m00_axi_rr_sched
module tb_zynq_m00_axi_rr_sched;
  localparam int N = 2;
  localparam int A = 32;
  localparam int D = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn;
  logic [N-1:0] req_v, req_w, req_yumi, wdata_v, wdata_yumi, rdata_v, rdata_ready, done_v;
  logic [N*A-1:0] req_addr;
  logic [N*4-1:0] req_len;
  logic [N*D-1:0] wdata;
  logic [N*D/8-1:0] wstrb;
  logic [D-1:0] rdata;
  logic done_err;
  logic [A-1:0] awaddr, araddr;
  logic awvalid, awready, arvalid, arready;
  logic [5:0] awid, arid, wid, bid, rid;
  logic [3:0] awlen, arlen, awcache, arcache, awqos, arqos;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, awlock, arlock, bresp, rresp;
  logic [D-1:0] wdata_ax, rdata_ax;
  logic [D/8-1:0] wstrb_ax;
  logic wvalid, wlast, wready, bready, bvalid, rready, rvalid, rlast;

  zynq_m00_axi_rr_sched #(.num_req_p(N), .addr_width_p(A), .data_width_p(D)) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(aresetn),
    .req_v_i(req_v), .req_w_i(req_w), .req_addr_i(req_addr), .req_len_i(req_len),
    .req_yumi_o(req_yumi), .wdata_i(wdata), .wstrb_i(wstrb), .wdata_v_i(wdata_v),
    .wdata_yumi_o(wdata_yumi), .rdata_o(rdata), .rdata_v_o(rdata_v),
    .rdata_ready_i(rdata_ready), .done_v_o(done_v), .done_err_o(done_err),
    .m00_axi_awaddr(awaddr), .m00_axi_awvalid(awvalid), .m00_axi_awid(awid),
    .m00_axi_awlen(awlen), .m00_axi_awsize(awsize), .m00_axi_awburst(awburst),
    .m00_axi_awlock(awlock), .m00_axi_awcache(awcache), .m00_axi_awprot(awprot),
    .m00_axi_awqos(awqos), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata_ax), .m00_axi_wstrb(wstrb_ax), .m00_axi_wvalid(wvalid),
    .m00_axi_wlast(wlast), .m00_axi_wid(wid), .m00_axi_wready(wready),
    .m00_axi_bready(bready), .m00_axi_bvalid(bvalid), .m00_axi_bid(bid), .m00_axi_bresp(bresp),
    .m00_axi_araddr(araddr), .m00_axi_arvalid(arvalid), .m00_axi_arid(arid),
    .m00_axi_arlen(arlen), .m00_axi_arsize(arsize), .m00_axi_arburst(arburst),
    .m00_axi_arlock(arlock), .m00_axi_arcache(arcache), .m00_axi_arprot(arprot),
    .m00_axi_arqos(arqos), .m00_axi_arready(arready),
    .m00_axi_rready(rready), .m00_axi_rdata(rdata_ax), .m00_axi_rvalid(rvalid),
    .m00_axi_rid(rid), .m00_axi_rlast(rlast), .m00_axi_rresp(rresp)
  );

  typedef struct {
    int r; bit w; logic [31:0] addr; logic [3:0] len; int stall;
    logic [1:0] bresp; logic [1:0] rresp; int rlast_at; bit exp_err;
  } vec_t;
  typedef struct { int r; logic [31:0] addr; logic [3:0] len; bit exp_err; } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int exp_rr = 0;
  int done_cnt = 0;

  int stall_cfg = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  int rlast_at_cfg = -1;

  int aw_cnt, ar_cnt, w_beats, w_len, r_beats, r_len, r_last_tgt;
  bit aw_seen, ar_seen, w_active, b_pend, r_active;
  logic [31:0] aw_addr0, ar_addr0;
  logic [3:0] aw_len0, ar_len0;
  int lane_beat [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int r);
    return N'(1) << r;
  endfunction
  function automatic logic [63:0] wpat(input int lane, input int beat);
    return {32'hC0DE_0000 | 32'(lane), 32'h5A5A_0000 ^ 32'(beat)};
  endfunction
  function automatic logic [63:0] rpat(input int beat);
    return {32'hBEEF_0000 | 32'(beat), 32'h1234_5678};
  endfunction
  function automatic logic [7:0] spat(input int lane);
    return (lane == 0) ? 8'hFF : 8'h3C;
  endfunction

  // AXI slave model plus done monitor; samples on negedge, drives after posedge.
  initial begin
    logic n_awready, n_arready, n_bvalid, n_rvalid, n_rlast;
    logic [D-1:0] n_rdata;
    int own;
    exp_t e;
    awready = 0; wready = 1; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rdata_ax = 0; rid = 0; rlast = 0; rresp = 0;
    aw_cnt = 0; ar_cnt = 0; w_beats = 0; w_len = 0; r_beats = 0; r_len = 0; r_last_tgt = 0;
    aw_seen = 0; ar_seen = 0; w_active = 0; b_pend = 0; r_active = 0;
    aw_addr0 = 0; ar_addr0 = 0; aw_len0 = 0; ar_len0 = 0;
    for (int i = 0; i < N; i++) lane_beat[i] = 0;
    forever begin
      @(negedge clk);
      own = (sb_q.size() > 0) ? sb_q[0].r : 0;
      if (!aresetn) begin
        aw_cnt = 0; ar_cnt = 0; aw_seen = 0; ar_seen = 0;
        w_active = 0; w_beats = 0; b_pend = 0; r_active = 0; r_beats = 0;
      end else begin
        if (wvalid) begin
          if (!w_active) chk("wvalid_before_aw", 1, 0);
          else if (wready) begin
            chk("wdata", wdata_ax, wpat(own, w_beats));
            chk("wstrb", wstrb_ax, spat(own));
            chk("wlast", wlast, w_beats == w_len);
            chk("wid", wid, 0);
            chk("wdata_yumi", wdata_yumi, oh(own));
            lane_beat[own]++;
            w_beats++;
            if (w_beats > w_len) begin w_active = 0; b_pend = 1; end
          end
        end
        if (awvalid) begin
          if (!aw_seen) begin
            aw_seen = 1; aw_addr0 = awaddr; aw_len0 = awlen;
            chk("awaddr", awaddr, (sb_q.size() > 0) ? sb_q[0].addr : 32'hFFFF_FFFF);
            chk("awlen", awlen, (sb_q.size() > 0) ? sb_q[0].len : 4'hF);
            chk("aw_fixed", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
                {6'd0, 3'd3, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000});
          end else begin
            chk("aw_stable", {awaddr, awlen}, {aw_addr0, aw_len0});
          end
          if (awready) begin
            chk("aw_stall_cycles", aw_cnt, stall_cfg);
            aw_seen = 0; aw_cnt = 0; w_active = 1; w_beats = 0; w_len = int'(awlen);
            for (int i = 0; i < N; i++) lane_beat[i] = 0;
          end else aw_cnt++;
        end
        if (bvalid && bready) b_pend = 0;
        if (arvalid) begin
          if (!ar_seen) begin
            ar_seen = 1; ar_addr0 = araddr; ar_len0 = arlen;
            chk("araddr", araddr, (sb_q.size() > 0) ? sb_q[0].addr : 32'hFFFF_FFFF);
            chk("arlen", arlen, (sb_q.size() > 0) ? sb_q[0].len : 4'hF);
            chk("ar_fixed", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
                {6'd0, 3'd3, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000});
          end else begin
            chk("ar_stable", {araddr, arlen}, {ar_addr0, ar_len0});
          end
          if (arready) begin
            ar_seen = 0; ar_cnt = 0; r_active = 1; r_beats = 0; r_len = int'(arlen);
            r_last_tgt = (rlast_at_cfg >= 0) ? rlast_at_cfg : r_len;
          end else ar_cnt++;
        end
        if (rvalid) begin
          chk("rdata_v", rdata_v, oh(own));
          if (rready) begin
            chk("rdata", rdata, rdata_ax);
            r_beats++;
            if (rlast) r_active = 0;
          end
        end
        if (done_v != 0) begin
          if (sb_q.size() == 0) chk("done_unexpected", done_v, 0);
          else begin
            e = sb_q.pop_front();
            chk("done_v", done_v, oh(e.r));
            chk("done_err", done_err, e.exp_err);
            done_cnt++;
          end
        end
      end
      n_awready = (aw_cnt >= stall_cfg);
      n_arready = (ar_cnt >= stall_cfg);
      n_bvalid  = b_pend;
      n_rvalid  = r_active;
      n_rdata   = rpat(r_beats);
      n_rlast   = r_active && (r_beats == r_last_tgt);
      @(posedge clk);
      #1;
      awready = n_awready; arready = n_arready; bvalid = n_bvalid; bresp = bresp_cfg;
      rvalid = n_rvalid; rdata_ax = n_rdata; rlast = n_rlast; rresp = rresp_cfg;
      for (int i = 0; i < N; i++) wdata[i*D +: D] = wpat(i, lane_beat[i]);
    end
  end

  task automatic issue(input vec_t v);
    bit ok;
    stall_cfg = v.stall; bresp_cfg = v.bresp; rresp_cfg = v.rresp; rlast_at_cfg = v.rlast_at;
    req_w[v.r] = v.w;
    req_addr[v.r*A +: A] = v.addr;
    req_len[v.r*4 +: 4] = v.len;
    req_v[v.r] = 1'b1;
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); #1;
      if (req_yumi != 0) ok = 1;
    end
    if (!ok) chk("yumi_timeout", 0, 1);
    else begin
      chk("yumi", req_yumi, oh(v.r));
      sb_q.push_back('{v.r, v.addr, v.len, v.exp_err});
      exp_rr = (v.r + 1) % N;
    end
    @(posedge clk); #1;
    req_v[v.r] = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int t = 0; t < 300 && done_cnt < target; t++) begin
      @(negedge clk); #1;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic run_vec(input vec_t v);
    int tgt;
    tgt = done_cnt + 1;
    issue(v);
    wait_done(tgt);
  endtask

  // Both requesters hold len-0 reads; grants must follow the bench's pointer model.
  task automatic both_held(input int n);
    int base;
    bit ok;
    base = done_cnt;
    stall_cfg = 0; bresp_cfg = 0; rresp_cfg = 0; rlast_at_cfg = -1;
    for (int r = 0; r < N; r++) begin
      req_w[r] = 1'b0;
      req_addr[r*A +: A] = 32'h9000 + 32'(r) * 32'h100;
      req_len[r*4 +: 4] = 4'd0;
    end
    req_v = '1;
    for (int k = 0; k < n; k++) begin
      ok = 0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk); #1;
        if (req_yumi != 0) ok = 1;
      end
      if (!ok) chk("rr_timeout", 0, 1);
      else begin
        chk("rr_grant", req_yumi, oh(exp_rr));
        sb_q.push_back('{exp_rr, 32'h9000 + 32'(exp_rr) * 32'h100, 4'd0, 1'b0});
        exp_rr = (exp_rr + 1) % N;
      end
    end
    @(posedge clk); #1;
    req_v = '0;
    wait_done(base + n);
  endtask

  vec_t vecs [8];

  initial begin
    vec_t rv;
    bit ok;
    vecs[0] = '{0, 1'b0, 32'h1000, 4'd3,  0, 2'b00, 2'b00, -1, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h2000, 4'd1,  0, 2'b00, 2'b00, -1, 1'b0};
    vecs[2] = '{0, 1'b1, 32'h3000, 4'd2,  5, 2'b00, 2'b00, -1, 1'b0};
    vecs[3] = '{1, 1'b1, 32'h4000, 4'd0,  0, 2'b10, 2'b00, -1, 1'b1};
    vecs[4] = '{0, 1'b0, 32'h5000, 4'd3,  0, 2'b00, 2'b00,  2, 1'b1};
    vecs[5] = '{1, 1'b0, 32'h6000, 4'd1,  2, 2'b00, 2'b10, -1, 1'b1};
    vecs[6] = '{0, 1'b0, 32'h7000, 4'd1,  0, 2'b00, 2'b00,  3, 1'b1};
    vecs[7] = '{1, 1'b0, 32'h8000, 4'd15, 0, 2'b00, 2'b00, -1, 1'b0};

    aresetn = 1'b0; req_v = '0; req_w = '0; req_addr = '0; req_len = '0;
    wdata_v = '1; rdata_ready = '1; wdata = '0;
    for (int i = 0; i < N; i++) wstrb[i*8 +: 8] = spat(i);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("reset_strobes", {req_yumi, done_v, done_err, wdata_yumi, rdata_v}, 0);
    @(posedge clk); #1;
    aresetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    both_held(4);

    rv = '{0, 1'b1, 32'hA000, 4'd7, 0, 2'b00, 2'b00, -1, 1'b0};
    issue(rv);
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk); #1;
      if (w_active && w_beats >= 2) ok = 1;
    end
    if (!ok) chk("w_beat2_timeout", 0, 1);
    aresetn = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("reset_mid_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("reset_mid_strobes", {req_yumi, done_v, wdata_yumi, rdata_v}, 0);
    sb_q.delete();
    exp_rr = 0;
    @(posedge clk); #1;
    aresetn = 1'b1;

    both_held(2);
    rv = '{1, 1'b0, 32'hB000, 4'd3, 0, 2'b00, 2'b00, -1, 1'b0};
    run_vec(rv);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
